// File: rtl/wired_dispatch_n.sv
`default_nettype none
//----------------------------------------------------------------------------
//  Module      : wired_dispatch_n
//  Description : N-wide dispatch (P) stage between rename and the issue
//                queues. Holds one renamed bundle of WIDTH lanes and keeps
//                capturing source operands from the CDB ports and the ROB
//                read-back while the bundle waits. Lanes issue in order
//                against per-FU credits. A partial bundle may issue, and the
//                lanes left over keep their positions.
//  Revision    : 1.0 - initial N-wide, partial-issue version
//
//  Configuration macro:
//    WIRED_DISPATCH_CDB_BANK_EN - when defined, each operand is compared only
//      against the CDB port selected by its low id bits (CDB_CNT >= 2, power
//      of two). The CDB arbiter must steer ids by those bits. When undefined,
//      each operand compares its full id against every CDB port.
//
//  Ports:
//    clk, rst_n     clock, synchronous active-low reset
//    flush_i        pipeline flush: drops held and incoming lanes
//    r_*_i          incoming renamed bundle (per lane / per operand)
//    r_ready_o      bundle accepted this cycle
//    cdb_*_i        CDB broadcast ports
//    rob_rreg_o     held source ids, used for the ROB read
//    rob_*_i        same-cycle ROB read-back per operand
//    fu_credit_i    slots each FU accepts this cycle
//    p_*_o          issued lanes with their operand view
//----------------------------------------------------------------------------
`ifndef _WIRED_PARAM_ROB_LEN
`define _WIRED_PARAM_ROB_LEN 6
`endif

module wired_dispatch_n #(
  parameter int WIDTH   = 2,
  parameter int CDB_CNT = 2,
  parameter int FU_CNT  = 4,
  parameter int ROB_LEN = `_WIRED_PARAM_ROB_LEN,
  parameter int CTRL_W  = 128
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush_i,
  input  logic [WIDTH-1:0]                       r_valid_i,
  output logic                                   r_ready_o,
  input  logic [WIDTH*CTRL_W-1:0]                r_ctrl_i,
  input  logic [WIDTH*FU_CNT-1:0]                r_fu_sel_i,
  input  logic [WIDTH*2*ROB_LEN-1:0]             r_rreg_i,
  input  logic [WIDTH*2-1:0]                     r_rvalid_i,
  input  logic [WIDTH*2*32-1:0]                  r_rdata_i,
  input  logic [WIDTH*2-1:0]                     r_scyc_raw_i,
  input  logic [CDB_CNT-1:0]                     cdb_valid_i,
  input  logic [CDB_CNT*ROB_LEN-1:0]             cdb_wid_i,
  input  logic [CDB_CNT*32-1:0]                  cdb_wdata_i,
  output logic [WIDTH*2*ROB_LEN-1:0]             rob_rreg_o,
  input  logic [WIDTH*2-1:0]                     rob_valid_i,
  input  logic [WIDTH*2*32-1:0]                  rob_data_i,
  input  logic [FU_CNT*$clog2(WIDTH+1)-1:0]      fu_credit_i,
  output logic [WIDTH-1:0]                       p_valid_o,
  output logic [WIDTH*CTRL_W-1:0]                p_ctrl_o,
  output logic [WIDTH*2*32-1:0]                  p_rdata_o,
  output logic [WIDTH*2-1:0]                     p_rvalid_o
);

  localparam int CRED_W = $clog2(WIDTH + 1);
  localparam int OPS    = WIDTH * 2;
  localparam int BANK_W = (CDB_CNT > 1) ? $clog2(CDB_CNT) : 1;

  // Held bundle state
  logic [WIDTH-1:0]   held;
  logic [CTRL_W-1:0]  ctrl        [WIDTH];
  logic [FU_CNT-1:0]  fu_sel      [WIDTH];
  logic [ROB_LEN-1:0] rreg        [OPS];
  logic [OPS-1:0]     rvalid;
  logic [31:0]        rdata       [OPS];
  logic [OPS-1:0]     raw_pending;

  // Operand view
  logic [OPS-1:0]     cdb_hit;
  logic [31:0]        cdb_data    [OPS];
  logic [OPS-1:0]     view_valid;
  logic [31:0]        view_data   [OPS];
  logic [OPS-1:0]     view_raw;

  // Issue / accept
  logic [WIDTH-1:0]   issue_raw;
  logic [WIDTH-1:0]   cred_ok;
  logic [CRED_W-1:0]  used        [FU_CNT];
  logic               chain_ok;
  logic               ready;

  //--------------------------------------------------------------------------
  // CDB match. Only held lanes look at the CDB: a lane accepted this cycle
  // relies on rename to have supplied the correct valid bit.
  //--------------------------------------------------------------------------
`ifdef WIRED_DISPATCH_CDB_BANK_EN
  // Low id bits select the port and are implied by the port index, so only
  // the upper id bits of each port take part in the compare.
  logic unused_wid_low;
  always_comb begin
    unused_wid_low = 1'b0;
    for (int p = 0; p < CDB_CNT; p++) begin
      unused_wid_low = unused_wid_low ^ (^cdb_wid_i[p*ROB_LEN +: BANK_W]);
    end
  end

  always_comb begin : b_cdb_bank
    int bank;
    bank = 0;
    for (int i = 0; i < OPS; i++) begin
      cdb_hit[i]  = 1'b0;
      cdb_data[i] = '0;
      bank        = int'(rreg[i][BANK_W-1:0]);
      if (held[i/2] && cdb_valid_i[bank] &&
          (cdb_wid_i[bank*ROB_LEN + BANK_W +: ROB_LEN-BANK_W] ==
           rreg[i][ROB_LEN-1:BANK_W])) begin
        cdb_hit[i]  = 1'b1;
        cdb_data[i] = cdb_wdata_i[bank*32 +: 32];
      end
    end
  end
`else
  // Full compare against every port. Ids are unique, so at most one port
  // hits and OR-merging the data is exact.
  always_comb begin
    for (int i = 0; i < OPS; i++) begin
      cdb_hit[i]  = 1'b0;
      cdb_data[i] = '0;
      for (int p = 0; p < CDB_CNT; p++) begin
        if (held[i/2] && cdb_valid_i[p] &&
            (cdb_wid_i[p*ROB_LEN +: ROB_LEN] == rreg[i])) begin
          cdb_hit[i]  = 1'b1;
          cdb_data[i] = cdb_data[i] | cdb_wdata_i[p*32 +: 32];
        end
      end
    end
  end
`endif

  //--------------------------------------------------------------------------
  // Operand view: CDB first, then ROB, then the stored value. The ROB is not
  // trusted while the producer is an earlier lane of the same bundle, since
  // its entry may not have been written yet.
  //--------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < OPS; i++) begin
      view_valid[i] = rvalid[i];
      view_data[i]  = rdata[i];
      view_raw[i]   = raw_pending[i];
      if (cdb_hit[i]) begin
        view_valid[i] = 1'b1;
        view_data[i]  = cdb_data[i];
        view_raw[i]   = 1'b0;
      end else if (held[i/2] && rob_valid_i[i] && !raw_pending[i]) begin
        view_valid[i] = 1'b1;
        view_data[i]  = rob_data_i[i*32 +: 32];
      end
    end
  end

  //--------------------------------------------------------------------------
  // In-order issue. A held lane that cannot issue breaks the chain for all
  // later lanes. Credits are consumed by earlier issuing lanes of the same FU.
  //--------------------------------------------------------------------------
  always_comb begin
    chain_ok  = 1'b1;
    issue_raw = '0;
    cred_ok   = '0;
    for (int f = 0; f < FU_CNT; f++) begin
      used[f] = '0;
    end
    for (int k = 0; k < WIDTH; k++) begin
      for (int f = 0; f < FU_CNT; f++) begin
        if (fu_sel[k][f] && (used[f] < fu_credit_i[f*CRED_W +: CRED_W])) begin
          cred_ok[k] = 1'b1;
        end
      end
      issue_raw[k] = held[k] && chain_ok && cred_ok[k];
      if (held[k] && !issue_raw[k]) begin
        chain_ok = 1'b0;
      end
      if (issue_raw[k]) begin
        for (int f = 0; f < FU_CNT; f++) begin
          if (fu_sel[k][f]) begin
            used[f] = used[f] + CRED_W'(1);
          end
        end
      end
    end
  end

  // The register is free once every held lane leaves this cycle.
  assign ready     = flush_i || (&(~held | issue_raw));
  assign r_ready_o = ready;
  assign p_valid_o = issue_raw & {WIDTH{~flush_i}};

  //--------------------------------------------------------------------------
  // Output packing
  //--------------------------------------------------------------------------
  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    assign p_ctrl_o[k*CTRL_W +: CTRL_W] = ctrl[k];
  end

  for (genvar i = 0; i < OPS; i++) begin : g_op
    assign p_rdata_o[i*32 +: 32]           = view_data[i];
    assign p_rvalid_o[i]                   = view_valid[i] && !view_raw[i];
    assign rob_rreg_o[i*ROB_LEN +: ROB_LEN] = rreg[i];
  end

  //--------------------------------------------------------------------------
  // State update
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held        <= '0;
      raw_pending <= '0;
      rvalid      <= '0;
      for (int k = 0; k < WIDTH; k++) begin
        ctrl[k]   <= '0;
        fu_sel[k] <= '0;
      end
      for (int i = 0; i < OPS; i++) begin
        rreg[i]  <= '0;
        rdata[i] <= '0;
      end
    end else if (flush_i) begin
      held        <= '0;
      raw_pending <= '0;
    end else if (ready) begin
      held        <= r_valid_i;
      raw_pending <= r_scyc_raw_i;
      rvalid      <= r_rvalid_i;
      for (int k = 0; k < WIDTH; k++) begin
        ctrl[k]   <= r_ctrl_i[k*CTRL_W +: CTRL_W];
        fu_sel[k] <= r_fu_sel_i[k*FU_CNT +: FU_CNT];
      end
      for (int i = 0; i < OPS; i++) begin
        rreg[i]  <= r_rreg_i[i*ROB_LEN +: ROB_LEN];
        rdata[i] <= r_rdata_i[i*32 +: 32];
      end
    end else begin
      // Lanes stay in place; unissued lanes absorb their operand view.
      for (int k = 0; k < WIDTH; k++) begin
        if (issue_raw[k]) begin
          held[k] <= 1'b0;
        end else begin
          for (int j = 0; j < 2; j++) begin
            rvalid[k*2+j]      <= view_valid[k*2+j];
            rdata[k*2+j]       <= view_data[k*2+j];
            raw_pending[k*2+j] <= view_raw[k*2+j];
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/wired_dispatch_n.md
# wired_dispatch_n

Parametrised N-wide dispatch (P) stage between rename and the issue queues. It holds one renamed bundle of `WIDTH` lanes and keeps capturing source operands from `CDB_CNT` CDB ports and from the ROB read-back while held. Lanes issue in order to `FU_CNT` functional-unit queues using per-FU credits, and partial-bundle issue is allowed, so one stalled FU no longer blocks earlier lanes. It replaces the fixed 2-wide, all-or-nothing P stage.

## Interface
Parameters:
- `WIDTH`, 2, lanes per bundle.
- `CDB_CNT`, 2, CDB ports; power of two.
- `FU_CNT`, 4, target issue queues.
- `ROB_LEN`, `_WIRED_PARAM_ROB_LEN`, ROB id width.
- `CTRL_W`, 128, opaque control payload width per lane.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `flush_i` in 1: pipeline flush.
- `r_valid_i` in WIDTH: per-lane valid from rename.
- `r_ready_o` out 1: bundle accepted this cycle.
- `r_ctrl_i` in WIDTH×CTRL_W: lane control payload.
- `r_fu_sel_i` in WIDTH×FU_CNT: one-hot target FU.
- `r_rreg_i` in WIDTH×2×ROB_LEN: source ROB ids.
- `r_rvalid_i` in WIDTH×2: operand already valid.
- `r_rdata_i` in WIDTH×2×32: operand data.
- `r_scyc_raw_i` in WIDTH×2: operand produced by an earlier lane of the same bundle.
- `cdb_valid_i` in CDB_CNT.
- `cdb_wid_i` in CDB_CNT×ROB_LEN.
- `cdb_wdata_i` in CDB_CNT×32.
- `rob_rreg_o` out WIDTH×2×ROB_LEN: held source ids, for ROB read.
- `rob_valid_i` in WIDTH×2.
- `rob_data_i` in WIDTH×2×32: same-cycle ROB read-back.
- `fu_credit_i` in FU_CNT×$clog2(WIDTH+1): slots each FU accepts this cycle.
- `p_valid_o` out WIDTH: lane issued this cycle.
- `p_ctrl_o` out WIDTH×CTRL_W.
- `p_rdata_o` out WIDTH×2×32.
- `p_rvalid_o` out WIDTH×2.

## Operation
Per-lane state:
- `held`, `ctrl`, `fu_sel`, `rreg`, `rvalid`, `rdata`, `raw_pending`.

Operand view, computed combinationally each cycle for every held operand:
- CDB hit: a CDB port is valid and its `wid` equals `rreg`. View takes the CDB data, valid=1, and `raw_pending` clears.
- Else ROB hit: `rob_valid_i` is set and `raw_pending`=0. View takes `rob_data_i`, valid=1.
- Else: the stored value.
- `p_rvalid_o` = view valid && !`raw_pending`.
- `p_rdata_o` = view data.
- The view is written back to state every cycle in which the lane is not issued.
- ROB read-back is ignored while `raw_pending`=1, because the ROB entry may be stale.

Issue rule:
- Lane k issues iff `held[k]`, every lower held lane issues, and the number of lower issuing lanes with the same `fu_sel` is less than `fu_credit_i` of that FU.
- `p_valid_o[k]` = issue_k. Issued lanes clear `held`. Remaining lanes keep their positions (no compaction).

Accept rule:
- `r_ready_o` = no lane held, or every held lane issues this cycle.
- When `r_ready_o`=1, the register loads the incoming bundle: `held` = `r_valid_i`, `raw_pending` = `r_scyc_raw_i`, other fields from the inputs.

Flush:
- `flush_i` has priority. All `held` bits clear next cycle, the incoming bundle is discarded, and `p_valid_o` is forced to 0.
- `r_ready_o` is 1 during flush, so the frontend drains.

Invariant: `fu_sel` is one-hot. A zero `fu_sel` never issues (it blocks later lanes); this is a bench assertion.

## Timing
- Reset: `held`=0 and `raw_pending`=0, so `p_valid_o`=0, `r_ready_o`=1, and all data outputs are 0.
- Latency: a bundle accepted in cycle t can issue at t+1 at the earliest.
- All outputs are combinational from state plus same-cycle CDB, ROB and credit inputs. There is no output register.
- CDB bypass reaches `p_rdata_o` in the same cycle.
- Back-to-back: full-rate issue when credits suffice, with no bubble between bundles.
- A CDB hit and issue in the same cycle: the issued lane carries the CDB value.
- A CDB hit on a lane accepted that same cycle is not seen. Rename provides a correct `r_rvalid_i` for that case.
- Multiple CDB hits on one operand are illegal (ROB ids are unique); the bench asserts this.

## Configuration
- `WIRED_DISPATCH_CDB_BANK_EN` defined:
  - Each operand compares only against CDB port `rreg[$clog2(CDB_CNT)-1:0]`, using the upper `ROB_LEN-$clog2(CDB_CNT)` bits.
  - The CDB arbiter must steer ids by their low bits.
  - One comparator per operand.
- Undefined:
  - Full `ROB_LEN` compare against all `CDB_CNT` ports, OR-reduced.
  - Works with any arbiter.

## Test plan
- Reset, then a 2-lane bundle with all operands valid and credits {1,1,1,1} to different FUs -> `r_ready_o`=1 at reset; both `p_valid_o` bits set at t+1; `r_ready_o`=1 at t+1.
- Lane0 → FU2 with credit 0, lane1 → FU1 -> nothing issues and `r_ready_o`=0. Raise the FU2 credit -> both lanes issue that cycle.
- Lane0 → FU0 with credit 1, lane1 → FU1 with credit 0 -> lane0 issues alone, lane1 stays held, `r_ready_o`=0. Next cycle give FU1 credit -> lane1 issues and `r_ready_o`=1.
- Held lane1 op0 with `raw_pending`, `rreg`=0x0B, `rob_valid_i`=1 -> `p_rvalid_o`=0. CDB `wid`=0x0B, data 0xDEADBEEF -> the same cycle shows rdata 0xDEADBEEF and valid=1, persisting after the CDB drops.
- Two lanes both → FU3 with credit 1 -> lane0 only; lane1 issues next cycle with credit 1.
- `flush_i` with 2 held lanes and a valid incoming bundle -> `p_valid_o`=0, `r_ready_o`=1, and `held`=0 the next cycle.
